fabric_mem_arb: RTL and testbench

Two-master, round-robin arbiter that shares the single word-wide memory port between the fabric's map-load reader (master 0) and its direction-writeback writer (master 1). It accepts one outstanding transaction at a time and drives the memory request/ready handshake. It returns read data or completion to the granted master, with an optional response timeout. It sits between the fabric controller and the system memory bus.

---
 rtl/fabric_mem_arb.sv | 130 +++++++++++++
 tb/tb_fabric_mem_arb.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fabric_mem_arb.sv
// Round-robin arbiter sharing one word-wide memory port between two fabric masters, one transaction in flight.
// Define FABRIC_ARB_TIMEOUT_EN to add the WAIT-state response timeout and the ERR abort path.
module fabric_mem_arb #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_done,
    output logic        m0_err,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] m1_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        busy,
    output logic        last_gnt
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fabric_mem_arb: TIMEOUT must lie in 1..255");
    end

`ifdef FABRIC_ARB_TIMEOUT_EN
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
`endif

    state_t state_q, state_d;
    logic   gnt_q;
    logic   any_req;
    logic   win;

`ifdef FABRIC_ARB_TIMEOUT_EN
    logic [7:0] timer_q;
    logic       timed_out;
    assign timed_out = (timer_q == 8'(TIMEOUT - 1));
`endif

    assign any_req = m0_req | m1_req;
    // On a tie the master that was not served last wins; otherwise the lone requester.
    assign win     = (m0_req & m1_req) ? ~gnt_q : m1_req;

    always_comb begin
        // NOTE: default assigned first so every path drives state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rdy) begin
                    state_d = S_RESP;
`ifdef FABRIC_ARB_TIMEOUT_EN
                end else if (timed_out) begin
                    state_d = S_ERR;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req  = (state_q == S_ISSUE);
    assign busy     = (state_q != S_IDLE);
    assign last_gnt = gnt_q;
    assign m0_done  = (state_q == S_RESP) & ~gnt_q;
    assign m1_done  = (state_q == S_RESP) &  gnt_q;
`ifdef FABRIC_ARB_TIMEOUT_EN
    assign m0_err   = (state_q == S_ERR) & ~gnt_q;
    assign m1_err   = (state_q == S_ERR) &  gnt_q;
`else
    assign m0_err   = 1'b0;
    assign m1_err   = 1'b0;
`endif

    // NOTE: synchronous reset clears the rdata registers too, since masters read them directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
`ifdef FABRIC_ARB_TIMEOUT_EN
            timer_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && any_req) begin
                gnt_q     <= win;
                mem_we    <= win ? m1_we    : m0_we;
                mem_addr  <= win ? m1_addr  : m0_addr;
                mem_wdata <= win ? m1_wdata : m0_wdata;
            end
            if (state_q == S_WAIT && mem_rdy) begin
                if (gnt_q) m1_rdata <= mem_rdata;
                else       m0_rdata <= mem_rdata;
            end
`ifdef FABRIC_ARB_TIMEOUT_EN
            if (state_q == S_ISSUE) begin
                timer_q <= '0;
            end else if (state_q == S_WAIT && !mem_rdy) begin
                // Abort zeroes the granted master's rdata so it reads 0 during the err pulse.
                if (timed_out) begin
                    if (gnt_q) m1_rdata <= '0;
                    else       m0_rdata <= '0;
                end else begin
                    timer_q <= timer_q + 8'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_fabric_mem_arb.sv
// Scoreboard bench for fabric_mem_arb: a transaction-level model predicts grant order, cycles and data.
`timescale 1ns/1ps
module tb_fabric_mem_arb;

    localparam int TIMEOUT = 16;
`ifdef FABRIC_ARB_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          lat;
    } txn_t;

    typedef struct {
        txn_t tx;
        int   issue_cyc;
    } mem_t;

    typedef struct {
        logic        m;
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk, rst;
    logic        m0_req, m0_we, m0_done, m0_err;
    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_done, m1_err;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic        mem_req, mem_we, mem_rdy, busy, last_gnt;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   mem_auto = 1'b1;
    mem_t mem_q[$];
    exp_t exp_q[$];
    logic        mlast = 1'b1;
    logic [31:0] mrdata[2] = '{32'd0, 32'd0};

    fabric_mem_arb #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .busy(busy), .last_gnt(last_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int lat);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata; t.lat = lat;
        return t;
    endfunction

    function automatic txn_t rand_txn();
        return mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, int'($urandom_range(1, 12)));
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_ctrl"}, 32'({busy, mem_req, mem_we, m0_done, m0_err, m1_done, m1_err}), 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        check({tag, "_m0_rdata"}, m0_rdata, 32'd0);
        check({tag, "_m1_rdata"}, m1_rdata, 32'd0);
        check({tag, "_last_gnt"}, 32'(last_gnt), 32'd1);
    endtask

    // Raise the chosen requests in an IDLE cycle, predict every completion, then serve until all drop.
    task automatic run_round(input logic r0, input logic r1, input txn_t a, input txn_t b);
        logic order[$];
        logic first;
        int   t;
        int   deadline;
        t = cyc;
        m0_req = r0; m0_we = a.we; m0_addr = a.addr; m0_wdata = a.wdata;
        m1_req = r1; m1_we = b.we; m1_addr = b.addr; m1_wdata = b.wdata;
        first = (r0 && r1) ? !mlast : r1;
        order.push_back(first);
        if (r0 && r1) order.push_back(!first);
        foreach (order[i]) begin
            txn_t tx;
            mem_t me;
            exp_t e;
            if (order[i]) tx = b;
            else          tx = a;
            me.tx = tx;
            me.issue_cyc = t + 1;
            mem_q.push_back(me);
            e.m = order[i];
            if (TOUT_EN && tx.lat > TIMEOUT) begin
                e.err = 1'b1; e.rdata = 32'd0; e.cyc = t + 2 + TIMEOUT;
            end else begin
                e.err = 1'b0; e.rdata = tx.rdata; e.cyc = t + 2 + tx.lat;
            end
            exp_q.push_back(e);
            mlast = order[i];
            mrdata[order[i]] = e.rdata;
            t = e.cyc + 1;
        end
        deadline = t + 3;
        while ((m0_req || m1_req) && cyc < deadline) begin
            @(negedge clk);
            if (m0_done || m0_err) m0_req = 1'b0;
            if (m1_done || m1_err) m1_req = 1'b0;
        end
        if (m0_req || m1_req) begin
            check("round_timeout", 32'({m0_req, m1_req}), 32'd0);
            m0_req = 1'b0;
            m1_req = 1'b0;
        end
        @(posedge clk); #1;
        check("m0_rdata_hold", m0_rdata, mrdata[0]);
        check("m1_rdata_hold", m1_rdata, mrdata[1]);
    endtask

    // Memory side: checks each issued request against the model, then answers after its latency.
    initial begin : responder
        mem_t me;
        logic stable;
        mem_rdy = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req && mem_auto && !rst) begin
                if (mem_q.size() == 0) begin
                    check("mem_unexpected_req", 32'(mem_req), 32'd0);
                end else begin
                    me = mem_q.pop_front();
                    check("mem_issue_cyc", cyc, me.issue_cyc);
                    check("mem_we", 32'(mem_we), 32'(me.tx.we));
                    check("mem_addr", mem_addr, me.tx.addr);
                    check("mem_wdata", mem_wdata, me.tx.wdata);
                    stable = 1'b1;
                    for (int i = 0; i < me.tx.lat; i++) begin
                        @(posedge clk); #1;
                        if (i == 0 && mem_req) stable = 1'b0;
                        if (mem_we !== me.tx.we || mem_addr !== me.tx.addr || mem_wdata !== me.tx.wdata)
                            stable = 1'b0;
                    end
                    check("mem_stable_single_req", 32'(stable), 32'd1);
                    mem_rdy = 1'b1;
                    mem_rdata = me.tx.rdata;
                    @(posedge clk); #1;
                    mem_rdy = 1'b0;
                    mem_rdata = $urandom;
                end
            end
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [3:0] want;
        if (!rst && (m0_done || m0_err || m1_done || m1_err)) begin
            if (!TOUT_EN) check("err_tied_off", 32'({m0_err, m1_err}), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'({m0_done, m0_err, m1_done, m1_err}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                want = e.m ? {2'b00, ~e.err, e.err} : {~e.err, e.err, 2'b00};
                check("resp_cycle", cyc, e.cyc);
                check("resp_pulses", 32'({m0_done, m0_err, m1_done, m1_err}), 32'(want));
                check("resp_rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
                check("resp_last_gnt", 32'(last_gnt), 32'(e.m));
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish, expected finish within 50000 cycles");
        $fatal(1);
    end

    initial begin : stimulus
        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Both masters continuously requesting: grants alternate 0,1,0,1.
        run_round(1'b1, 1'b1, rand_txn(), rand_txn());
        run_round(1'b1, 1'b1, mk(1'b0, 32'h4000_0010, 32'd0, 32'hA5A5_0001, 1),
                              mk(1'b1, 32'h4000_2010, 32'h1111_2222, 32'hA5A5_0002, 1));
        // Master 0 read with the fastest possible response.
        run_round(1'b1, 1'b0, mk(1'b0, 32'h4000_0000, 32'd0, 32'h1234_5678, 1), rand_txn());
        // Master 1 write with the response held off to the sixth WAIT cycle.
        run_round(1'b0, 1'b1, rand_txn(), mk(1'b1, 32'h4000_2004, 32'hDEAD_BEEF, 32'h0BAD_F00D, 6));

`ifdef FABRIC_ARB_TIMEOUT_EN
        // No response within TIMEOUT: err, then a stray mem_rdy arrives while idle.
        run_round(1'b1, 1'b0, mk(1'b0, 32'h4000_0080, 32'd0, 32'hFEED_FACE, TIMEOUT + 3), rand_txn());
        repeat (3) @(posedge clk); #1;
        check("stray_rdy_dropped", m0_rdata, 32'd0);
        run_round(1'b1, 1'b0, mk(1'b0, 32'h4000_0084, 32'd0, 32'h600D_0001, 2), rand_txn());
`else
        // Slow memory: WAIT simply persists.
        run_round(1'b1, 1'b0, mk(1'b0, 32'h4000_0088, 32'd0, 32'h5104_0001, 1000), rand_txn());
`endif

        for (int n = 0; n < 40; n++) begin
            logic r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            run_round(r0, r1, rand_txn(), rand_txn());
        end

        // Reset during WAIT of a master 0 read while master 1 waits its turn.
        mem_auto = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h4000_0100; m0_wdata = 32'h0;
        @(posedge clk); #1;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h4000_2100; m1_wdata = 32'hCAFE_0001;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m0_req = 1'b0;
        mem_auto = 1'b1;
        mlast = 1'b1;
        mrdata[0] = 32'd0;
        mrdata[1] = 32'd0;
        @(negedge clk);
        check_reset_state("mid_reset");
        run_round(1'b0, 1'b1, rand_txn(), mk(1'b1, 32'h4000_2100, 32'hCAFE_0001, 32'h7777_0001, 3));

        for (int n = 0; n < 10; n++) begin
            run_round(1'b1, 1'b1, rand_txn(), rand_txn());
        end

        repeat (5) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
